battleship_game_fsm: RTL and testbench

- Parametrised top-level sequencer for the battleship lab game.
- Owns both boards and the player cursor, drives player ship placement, PC random placement, alternating turns, hit/miss marking and win detection.
- Generalises the fixed 5x5 / 5-ship setup to configurable board size, ship count and a player turn timeout.
- Sits between the debounced button front-end / LFSR and the VGA/7-segment display logic.

---
 rtl/battleship_pkg.sv | 28 ++
 rtl/battleship_game_fsm_board_cursor.sv | 54 +++++
 rtl/battleship_game_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_battleship_game_fsm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared types for the battleship game: cell encoding, game states and
// the flat cell index used by both boards.
package battleship_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    MISS  = 2'd2,
    HIT   = 2'd3
  } cell_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P_SETUP  = 3'd1,
    PC_SETUP = 3'd2,
    P_TURN   = 3'd3,
    PC_TURN  = 3'd4,
    CHECK    = 3'd5,
    DONE     = 3'd6
  } game_state_t;

  // Row-major cell index: cell (x,y) lives at y*n + x.
  function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                      input int unsigned n);
    return y * n + x;
  endfunction

endpackage

// File: rtl/battleship_game_fsm_board_cursor.sv
// Wrap-around board cursor. One move per cycle with priority
// up > down > left > right; a place press in the same cycle wins and
// suppresses the move.
module board_cursor #(
  parameter int BOARD_N = 5,
  parameter int COORD_W = (BOARD_N > 1) ? $clog2(BOARD_N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               place,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y
);

  localparam logic [COORD_W-1:0] LAST = COORD_W'(BOARD_N - 1);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  // Next cursor position: clear wins, then one prioritised move when enabled.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en && !place) begin
      if (up)         y_d = (y_q == '0)   ? LAST : y_q - COORD_W'(1);
      else if (down)  y_d = (y_q == LAST) ? '0   : y_q + COORD_W'(1);
      else if (left)  x_d = (x_q == '0)   ? LAST : x_q - COORD_W'(1);
      else if (right) x_d = (x_q == LAST) ? '0   : x_q + COORD_W'(1);
    end
  end

  // Cursor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign cursor_x = x_q;
  assign cursor_y = y_q;

endmodule

// File: rtl/battleship_game_fsm.sv
// Battleship game sequencer: owns both boards, runs ship placement,
// alternating shots with a player timeout, and win detection.
module battleship_game_fsm
  import battleship_pkg::*;
#(
  parameter int BOARD_N      = 5,
  parameter int NUM_SHIPS    = 5,
  parameter int TURN_TIMEOUT = 50_000_000,
  localparam int COORD_W     = (BOARD_N > 1) ? $clog2(BOARD_N) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           boton_arriba,
  input  logic                           boton_abajo,
  input  logic                           boton_izquierda,
  input  logic                           boton_derecha,
  input  logic                           boton_colocar,
  input  logic [COORD_W-1:0]             rand_x,
  input  logic [COORD_W-1:0]             rand_y,
  output logic [COORD_W-1:0]             cursor_x,
  output logic [COORD_W-1:0]             cursor_y,
  output logic [2:0]                     state_o,
  output logic [2*BOARD_N*BOARD_N-1:0]   player_board,
  output logic [2*BOARD_N*BOARD_N-1:0]   pc_board,
  output logic [7:0]                     player_hits,
  output logic [7:0]                     pc_hits,
  output logic                           game_over,
  output logic                           player_won
);

  localparam int NCELL  = BOARD_N * BOARD_N;
  localparam int CELL_W = $clog2(NCELL);
  localparam int PL_W   = $clog2(NUM_SHIPS + 1);
  localparam int TO_W   = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);
  localparam logic [PL_W-1:0]    PL_DONE  = PL_W'(NUM_SHIPS);
  localparam logic [7:0]         HIT_DONE = 8'(NUM_SHIPS);
  localparam logic [COORD_W:0]   N_EXT    = (COORD_W + 1)'(BOARD_N);

  game_state_t       state_q, state_d, ret_q, ret_d;
  cell_t             pb_q [NCELL];
  cell_t             pb_d [NCELL];
  cell_t             cb_q [NCELL];
  cell_t             cb_d [NCELL];
  logic [PL_W-1:0]   placed_q, placed_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [7:0]        ph_q, ph_d, pch_q, pch_d;
  logic              go_q, go_d, won_q, won_d;
  logic              cur_clr, cur_en;
  logic [CELL_W-1:0] cur_i, rnd_i;
  logic              rnd_ok;

  assign cur_i  = CELL_W'(idx(32'(cursor_x), 32'(cursor_y), BOARD_N));
  assign rnd_i  = CELL_W'(idx(32'(rand_x), 32'(rand_y), BOARD_N));
  assign rnd_ok = ({1'b0, rand_x} < N_EXT) && ({1'b0, rand_y} < N_EXT);
  assign cur_en = (state_q == P_SETUP) || (state_q == P_TURN);

  board_cursor #(.BOARD_N(BOARD_N), .COORD_W(COORD_W)) u_cursor (
    .clk      (clk),
    .rst_n    (rst),
    .en       (cur_en),
    .clr      (cur_clr),
    .place    (boton_colocar),
    .up       (boton_arriba),
    .down     (boton_abajo),
    .left     (boton_izquierda),
    .right    (boton_derecha),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y)
  );

  // Next-state, board writes and counters; the timeout counter is zero
  // unless it is explicitly advanced while waiting for a player shot.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    pb_d     = pb_q;
    cb_d     = cb_q;
    placed_d = placed_q;
    to_d     = '0;
    ph_d     = ph_q;
    pch_d    = pch_q;
    go_d     = go_q;
    won_d    = won_q;
    cur_clr  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = P_SETUP;
          for (int i = 0; i < NCELL; i++) begin
            pb_d[i] = EMPTY;
            cb_d[i] = EMPTY;
          end
          placed_d = '0;
          ph_d     = '0;
          pch_d    = '0;
          go_d     = 1'b0;
          won_d    = 1'b0;
          cur_clr  = 1'b1;
        end
      end
      P_SETUP: begin
        if (boton_colocar && pb_q[cur_i] == EMPTY) begin
          pb_d[cur_i] = SHIP;
          if (placed_q + PL_W'(1) == PL_DONE) begin
            placed_d = '0;
            state_d  = PC_SETUP;
          end else begin
            placed_d = placed_q + PL_W'(1);
          end
        end
      end
      PC_SETUP: begin
        if (rnd_ok && cb_q[rnd_i] == EMPTY) begin
          cb_d[rnd_i] = SHIP;
          if (placed_q + PL_W'(1) == PL_DONE) begin
            placed_d = '0;
            state_d  = P_TURN;
          end else begin
            placed_d = placed_q + PL_W'(1);
          end
        end
      end
      P_TURN: begin
        if (boton_colocar && (cb_q[cur_i] == EMPTY || cb_q[cur_i] == SHIP)) begin
          if (cb_q[cur_i] == SHIP) begin
            cb_d[cur_i] = HIT;
            ph_d        = ph_q + 8'd1;
          end else begin
            cb_d[cur_i] = MISS;
          end
          ret_d   = PC_TURN;
          state_d = CHECK;
        end else if (TURN_TIMEOUT != 0 && to_q == TO_LAST) begin
          state_d = PC_TURN;
        end else if (TURN_TIMEOUT != 0) begin
          to_d = to_q + TO_W'(1);
        end
      end
      PC_TURN: begin
        if (rnd_ok && (pb_q[rnd_i] == EMPTY || pb_q[rnd_i] == SHIP)) begin
          if (pb_q[rnd_i] == SHIP) begin
            pb_d[rnd_i] = HIT;
            pch_d       = pch_q + 8'd1;
          end else begin
            pb_d[rnd_i] = MISS;
          end
          ret_d   = P_TURN;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (ph_q == HIT_DONE) begin
          state_d = DONE;
          go_d    = 1'b1;
          won_d   = 1'b1;
        end else if (pch_q == HIT_DONE) begin
          state_d = DONE;
          go_d    = 1'b1;
          won_d   = 1'b0;
        end else begin
          state_d = ret_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Game state, boards and counters; reset wipes everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ret_q    <= P_TURN;
      for (int i = 0; i < NCELL; i++) begin
        pb_q[i] <= EMPTY;
        cb_q[i] <= EMPTY;
      end
      placed_q <= '0;
      to_q     <= '0;
      ph_q     <= '0;
      pch_q    <= '0;
      go_q     <= 1'b0;
      won_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      pb_q     <= pb_d;
      cb_q     <= cb_d;
      placed_q <= placed_d;
      to_q     <= to_d;
      ph_q     <= ph_d;
      pch_q    <= pch_d;
      go_q     <= go_d;
      won_q    <= won_d;
    end
  end

  for (genvar i = 0; i < NCELL; i++) begin : g_pack
    assign player_board[i*2 +: 2] = pb_q[i];
    assign pc_board[i*2 +: 2]     = cb_q[i];
  end

  assign state_o     = state_q;
  assign player_hits = ph_q;
  assign pc_hits     = pch_q;
  assign game_over   = go_q;
  assign player_won  = won_q;

endmodule

// File: tb/tb_battleship_game_fsm.sv
// Scoreboard bench: a behavioural game model pushes expected outputs as
// each stimulus cycle is driven; they are popped and compared after the edge.
module tb_battleship_game_fsm;
  import battleship_pkg::*;

  localparam int N  = 5;
  localparam int NS = 5;
  localparam int TO = 10;
  localparam int CW = 3;
  localparam int NB = 2 * N * N;

  logic          clk, rst, start, bu, bd, bl, br, bc;
  logic [CW-1:0] rand_x, rand_y, cursor_x, cursor_y;
  logic [2:0]    state_o;
  logic [NB-1:0] player_board, pc_board;
  logic [7:0]    player_hits, pc_hits;
  logic          game_over, player_won;

  battleship_game_fsm #(.BOARD_N(N), .NUM_SHIPS(NS), .TURN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .boton_arriba(bu), .boton_abajo(bd), .boton_izquierda(bl),
    .boton_derecha(br), .boton_colocar(bc),
    .rand_x(rand_x), .rand_y(rand_y),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .state_o(state_o),
    .player_board(player_board), .pc_board(pc_board),
    .player_hits(player_hits), .pc_hits(pc_hits),
    .game_over(game_over), .player_won(player_won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model
  int            mstate, cx, cy, ph, pch, placed, pplaced;
  logic [NB-1:0] mpb, mcb;
  logic          mgo, mwon;
  int            n_cmp, n_err;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      0:       return 64'(state_o);
      1:       return 64'(player_board);
      2:       return 64'(pc_board);
      3:       return 64'({cursor_x, cursor_y});
      4:       return 64'(player_hits);
      5:       return 64'(pc_hits);
      default: return 64'({game_over, player_won});
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_all(input string tag);
    push({tag, "/state"}, 0, 64'(mstate));
    push({tag, "/pboard"}, 1, 64'(mpb));
    push({tag, "/cboard"}, 2, 64'(mcb));
    push({tag, "/cursor"}, 3, 64'({3'(cx), 3'(cy)}));
    push({tag, "/phits"}, 4, 64'(ph));
    push({tag, "/pchits"}, 5, 64'(pch));
    push({tag, "/over_won"}, 6, 64'({mgo, mwon}));
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic cycle(input string tag);
    push_all(tag);
    @(posedge clk); #1;
    drain();
  endtask

  function automatic int ci(input int x, input int y);
    return (y * N + x) * 2;
  endfunction

  task automatic model_reset();
    mstate = 0; cx = 0; cy = 0; ph = 0; pch = 0; placed = 0; pplaced = 0;
    mpb = '0; mcb = '0; mgo = 1'b0; mwon = 1'b0;
  endtask

  task automatic pulse(input logic c, input logic u, input logic d, input logic l,
                       input logic r, input string tag);
    bc = c; bu = u; bd = d; bl = l; br = r;
    cycle(tag);
    bc = 0; bu = 0; bd = 0; bl = 0; br = 0;
  endtask

  task automatic move_to(input int x, input int y);
    while (cx != x) begin cx = (cx + 1) % N; pulse(0, 0, 0, 0, 1, "mv_r"); end
    while (cy != y) begin cy = (cy + 1) % N; pulse(0, 0, 1, 0, 0, "mv_d"); end
  endtask

  task automatic game_start();
    start = 1'b1;
    model_reset();
    mstate = 1;
    cycle("start");
    start = 1'b0;
  endtask

  task automatic place_at(input int x, input int y);
    move_to(x, y);
    if (mpb[ci(x, y) +: 2] == 2'd0) begin
      mpb[ci(x, y) +: 2] = 2'd1;
      placed++;
      if (placed == NS) begin placed = 0; mstate = 2; end
    end
    pulse(1, 0, 0, 0, 0, "place");
  endtask

  task automatic pc_rand(input int rx, input int ry);
    rand_x = 3'(rx); rand_y = 3'(ry);
    if (rx < N && ry < N && mcb[ci(rx, ry) +: 2] == 2'd0) begin
      mcb[ci(rx, ry) +: 2] = 2'd1;
      pplaced++;
      if (pplaced == NS) begin pplaced = 0; mstate = 3; end
    end
    cycle("pc_place");
  endtask

  task automatic check_step(input int ret);
    if (ph == NS) begin mstate = 6; mgo = 1'b1; mwon = 1'b1; end
    else if (pch == NS) begin mstate = 6; mgo = 1'b1; mwon = 1'b0; end
    else mstate = ret;
    cycle("check");
  endtask

  task automatic player_shot(input int x, input int y, input logic with_r);
    logic [1:0] c;
    bit fired;
    move_to(x, y);
    c = mcb[ci(x, y) +: 2];
    fired = 0;
    if (c < 2'd2) begin
      mcb[ci(x, y) +: 2] = (c == 2'd1) ? 2'd3 : 2'd2;
      if (c == 2'd1) ph++;
      mstate = 5;
      fired = 1;
    end
    pulse(1, 0, 0, 0, with_r, "shot");
    if (fired) check_step(4);
  endtask

  task automatic pc_shot(input int rx, input int ry);
    logic [1:0] c;
    bit fired;
    rand_x = 3'(rx); rand_y = 3'(ry);
    fired = 0;
    if (rx < N && ry < N) begin
      c = mpb[ci(rx, ry) +: 2];
      if (c < 2'd2) begin
        mpb[ci(rx, ry) +: 2] = (c == 2'd1) ? 2'd3 : 2'd2;
        if (c == 2'd1) pch++;
        mstate = 5;
        fired = 1;
      end
    end
    cycle("pc_shot");
    if (fired) check_step(3);
  endtask

  int pcx[6] = '{7, 1, 2, 2, 0, 4};
  int pcy[6] = '{7, 1, 3, 3, 4, 0};

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; start = 1'b0;
    bc = 0; bu = 0; bd = 0; bl = 0; br = 0;
    rand_x = 3'd7; rand_y = 3'd7;
    model_reset();
    cycle("reset");
    rst = 1'b1;
    cycle("idle");

    // game 1: cursor wrap, placement, PC placement with retries
    game_start();
    cy = 4; pulse(0, 1, 0, 0, 0, "wrap_up");
    cx = 4; pulse(0, 0, 0, 1, 0, "wrap_left");
    cx = 0; pulse(0, 0, 0, 0, 1, "wrap_right");
    cy = 0; pulse(0, 0, 1, 0, 0, "wrap_down");
    place_at(0, 0);
    place_at(0, 0);
    for (int i = 1; i < N; i++) place_at(i, 0);
    pc_rand(7, 7); pc_rand(7, 7); pc_rand(7, 7);
    for (int i = 0; i < 6; i++) pc_rand(pcx[i], pcy[i]);
    pc_rand(3, 3);

    // timeout: PC_TURN exactly TO cycles after P_TURN entry
    rand_x = 3'd7; rand_y = 3'd0;
    for (int i = 0; i < TO - 1; i++) cycle("to_wait");
    mstate = 4;
    cycle("to_fire");
    pc_shot(7, 0);
    pc_shot(2, 0);

    player_shot(4, 0, 1'b1);
    pc_shot(1, 1);
    player_shot(0, 0, 1'b0);
    pc_shot(2, 0);
    pc_shot(1, 2);
    player_shot(0, 0, 1'b0);
    player_shot(1, 1, 1'b0);
    pc_shot(1, 3);
    player_shot(2, 3, 1'b0);
    pc_shot(1, 4);
    player_shot(0, 4, 1'b0);
    pc_shot(2, 2);
    player_shot(3, 3, 1'b0);
    cycle("done_hold");

    // game 2: restart from DONE, ignored start, reset mid P_TURN
    game_start();
    place_at(0, 0);
    start = 1'b1; cycle("start_ign"); start = 1'b0;
    for (int i = 1; i < N; i++) place_at(i, 0);
    for (int i = 0; i < N; i++) pc_rand(i, 0);
    cycle("p_turn");
    rst = 1'b0;
    #1;
    model_reset();
    push_all("async_rst");
    drain();
    @(posedge clk); #1;
    rst = 1'b1;
    cycle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
